// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: owns the PC, fetches over req/ack, retires via valid/ready
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic [1:0]       npc_sel,
  input  logic             zero,
  input  logic [31:0]      rs_data,
  output logic             addr_err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             addr_err_q, addr_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      npc;
  logic [31:0]      br_off;
  logic [5:0]       unused_opcode;

  assign pc_plus4      = pc_q + 32'd4;
  assign br_off        = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign unused_opcode = instr_q[31:26];

  always_comb begin
    npc = pc_plus4;
    case (npc_sel)
      2'b01:   npc = zero ? (pc_plus4 + br_off) : pc_plus4;
      2'b10:   npc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      2'b11:   npc = {rs_data[31:2], 2'b00};
      default: npc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    addr_err_d = addr_err_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          pc_d    = npc;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = FETCH;
          // misaligned jr target is flagged, the PC itself is forced aligned
          if (npc_sel == 2'b11 && rs_data[1:0] != 2'b00) addr_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      addr_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      addr_err_q <= addr_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign addr_err    = addr_err_q;
  assign instr_count = cnt_q;

endmodule
